// File: rtl/rgb_bram_fetch.sv
// rgb_bram_fetch: issues pixel addresses to shared R/G/B BRAMs and packs the returned data into 64-bit pixels
module rgb_bram_fetch #(
    parameter int ADDR_WIDTH = 13,
    parameter int MAX        = 7056,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           frame_len,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  addr_valid,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [15:0]           dout_r,
    input  logic [15:0]           dout_g,
    input  logic [15:0]           dout_b,
    output logic [63:0]           pixel_data,
    output logic                  pixel_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  addr_ovf
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state;
    logic [15:0]         count;
    logic [15:0]         len;
    logic [RD_LATENCY:0] vld_pipe;
    logic [RD_LATENCY:0] inr_pipe;
    logic                accept;
    logic                in_range;

    assign accept   = (state == FETCH) && addr_valid;
    assign in_range = 32'(addr_in) < 32'(MAX);

    // Frame control: counts accepted addresses and waits for the read pipeline to empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            len        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            addr_ovf   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (addr_valid && state != FETCH) addr_ovf <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    addr_ovf <= addr_valid;
                    count    <= '0;
                    len      <= frame_len;
                    state    <= (frame_len == 16'd0) ? DONE : FETCH;
                    busy     <= frame_len != 16'd0;
                end
                FETCH: if (addr_valid) begin
                    count <= count + 16'd1;
                    if (count + 16'd1 == len) state <= DRAIN;
                end
                DRAIN: if (vld_pipe == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Address issue plus valid/in-range flags that ride alongside the BRAM read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            inr_pipe  <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], accept};
            inr_pipe <= {inr_pipe[RD_LATENCY-1:0], in_range};
            bram_en  <= accept && in_range;
            if (accept && in_range) bram_addr <= addr_in;
        end
    end

    // Output register: padding addresses produce a zero pixel, idle cycles hold the last pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
        end else begin
            pixel_valid <= vld_pipe[RD_LATENCY];
            if (vld_pipe[RD_LATENCY])
                pixel_data <= inr_pipe[RD_LATENCY] ? {16'd0, dout_r, dout_g, dout_b} : 64'd0;
        end
    end
endmodule

// File: tb/tb_rgb_bram_fetch.sv
// tb_rgb_bram_fetch: directed checks of rgb_bram_fetch at read latencies 1 and 3 against a pixel scoreboard
module tb_rgb_bram_fetch;
    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_len = '0;
    logic [12:0] addr_in = '0;
    logic        addr_valid = 1'b0;

    logic        en1, pv1, busy1, fd1, ovf1;
    logic [12:0] addr1;
    logic [63:0] pd1;
    logic        en3, pv3, busy3, fd3, ovf3;
    logic [12:0] addr3;
    logic [63:0] pd3;
    logic [47:0] s1 = '0, t0 = '0, t1 = '0, t2 = '0;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   done1 = -1;
    int   done3 = -1;
    int   last_k = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rgb_bram_fetch #(.ADDR_WIDTH(13), .MAX(7056), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .addr_in(addr_in), .addr_valid(addr_valid), .bram_en(en1), .bram_addr(addr1),
        .dout_r(s1[47:32]), .dout_g(s1[31:16]), .dout_b(s1[15:0]),
        .pixel_data(pd1), .pixel_valid(pv1), .busy(busy1), .frame_done(fd1), .addr_ovf(ovf1)
    );

    rgb_bram_fetch #(.ADDR_WIDTH(13), .MAX(7056), .RD_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .addr_in(addr_in), .addr_valid(addr_valid), .bram_en(en3), .bram_addr(addr3),
        .dout_r(t2[47:32]), .dout_g(t2[31:16]), .dout_b(t2[15:0]),
        .pixel_data(pd3), .pixel_valid(pv3), .busy(busy3), .frame_done(fd3), .addr_ovf(ovf3)
    );

    function automatic logic [15:0] mem_r(input logic [12:0] a);
        return {3'b0, a} * 16'd3 + 16'h0100;
    endfunction

    function automatic logic [15:0] mem_g(input logic [12:0] a);
        return {3'b0, a} ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mem_b(input logic [12:0] a);
        return ~{3'b0, a};
    endfunction

    function automatic logic [63:0] pix(input logic [12:0] a);
        return (a < 13'd7056) ? {16'd0, mem_r(a), mem_g(a), mem_b(a)} : 64'd0;
    endfunction

    // BRAM models: latency 1 for u1, latency 3 (read + two output stages) for u3
    always @(posedge clk) begin
        if (en1) s1 <= {mem_r(addr1), mem_g(addr1), mem_b(addr1)};
        if (en3) t0 <= {mem_r(addr3), mem_g(addr3), mem_b(addr3)};
        t1 <= t0;
        t2 <= t1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard monitors: every cycle compare pixel_valid/frame_done against the expected schedule
    always @(negedge clk) begin
        if (rst_n) begin
            logic e1, e3;
            e1 = q1.size() > 0 && q1[0].cyc == cyc;
            e3 = q3.size() > 0 && q3[0].cyc == cyc;
            chk("u1 pixel_valid", {63'd0, pv1}, {63'd0, e1});
            chk("u3 pixel_valid", {63'd0, pv3}, {63'd0, e3});
            if (e1) begin
                chk("u1 pixel_data", pd1, q1[0].data);
                void'(q1.pop_front());
            end
            if (e3) begin
                chk("u3 pixel_data", pd3, q3[0].data);
                void'(q3.pop_front());
            end
            chk("u1 frame_done", {63'd0, fd1}, {63'd0, cyc == done1});
            chk("u3 frame_done", {63'd0, fd3}, {63'd0, cyc == done3});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [12:0] a, input bit v);
        exp_t e;
        addr_in    = a;
        addr_valid = v;
        if (v) begin
            last_k = cyc + 1;
            e.data = pix(a);
            e.cyc  = last_k + 2;
            q1.push_back(e);
            e.cyc  = last_k + 4;
            q3.push_back(e);
        end
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic finish_frame;
        done1 = last_k + 4;
        done3 = last_k + 6;
        while (cyc <= done3) tick();
    endtask

    task automatic begin_frame(input logic [15:0] n);
        start     = 1'b1;
        frame_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " bram_en"}, {63'd0, en1}, 64'd0);
        chk({tag, " bram_addr"}, {51'd0, addr1}, 64'd0);
        chk({tag, " pixel_data"}, pd1, 64'd0);
        chk({tag, " pixel_valid"}, {63'd0, pv1}, 64'd0);
        chk({tag, " busy"}, {63'd0, busy1}, 64'd0);
        chk({tag, " frame_done"}, {63'd0, fd1}, 64'd0);
        chk({tag, " addr_ovf"}, {63'd0, ovf1}, 64'd0);
        chk({tag, " u3 pixel_valid"}, {63'd0, pv3}, 64'd0);
        chk({tag, " u3 busy"}, {63'd0, busy3}, 64'd0);
        chk({tag, " u3 bram_en"}, {63'd0, en3}, 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Four back-to-back addresses; a second start with a new length mid-frame must be ignored
        begin_frame(16'd4);
        chk("f1 busy", {63'd0, busy1}, 64'd1);
        start     = 1'b1;
        frame_len = 16'd9;
        for (int a = 0; a < 4; a++) begin
            feed(13'(a), 1'b1);
            chk("f1 bram_en", {63'd0, en1}, 64'd1);
            chk("f1 bram_addr", {51'd0, addr1}, 64'(a));
        end
        start = 1'b0;
        finish_frame();
        chk("f1 busy end", {63'd0, busy1}, 64'd0);
        chk("f1 pixel hold", pd1, pix(13'd3));
        chk("f1 u3 pixel hold", pd3, pix(13'd3));

        // Last in-range address followed by two padding addresses
        begin_frame(16'd3);
        feed(13'd7055, 1'b1);
        chk("pad bram_en 7055", {63'd0, en1}, 64'd1);
        chk("pad bram_addr 7055", {51'd0, addr1}, 64'd7055);
        feed(13'd7056, 1'b1);
        chk("pad bram_en 7056", {63'd0, en1}, 64'd0);
        chk("pad bram_addr hold 7056", {51'd0, addr1}, 64'd7055);
        feed(13'd7878, 1'b1);
        chk("pad bram_en 7878", {63'd0, en3}, 64'd0);
        chk("pad bram_addr hold 7878", {51'd0, addr3}, 64'd7055);
        finish_frame();

        // Zero-length frame: straight to DONE, never busy, no pixels
        start     = 1'b1;
        frame_len = 16'd0;
        done1     = cyc + 2;
        done3     = cyc + 2;
        tick();
        start = 1'b0;
        chk("zero busy", {63'd0, busy1}, 64'd0);
        tick();
        chk("zero busy u3", {63'd0, busy3}, 64'd0);
        tick();

        // Stray addresses in IDLE and DRAIN raise the sticky overflow flag
        feed(13'd50, 1'b0);
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        chk("ovf idle", {63'd0, ovf1}, 64'd1);
        tick();
        chk("ovf sticky", {63'd0, ovf1}, 64'd1);
        begin_frame(16'd1);
        chk("ovf cleared", {63'd0, ovf1}, 64'd0);
        feed(13'd10, 1'b1);
        addr_in    = 13'd20;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        chk("ovf drain", {63'd0, ovf1}, 64'd1);
        finish_frame();
        chk("ovf stays", {63'd0, ovf3}, 64'd1);
        begin_frame(16'd1);
        chk("ovf cleared again", {63'd0, ovf3}, 64'd0);
        feed(13'd11, 1'b1);
        finish_frame();

        // Reset mid-frame with two reads in flight discards them
        begin_frame(16'd4);
        feed(13'd100, 1'b1);
        feed(13'd101, 1'b1);
        rst_n = 1'b0;
        tick();
        q1.delete();
        q3.delete();
        done1 = -1;
        done3 = -1;
        chk_reset("midreset");
        rst_n = 1'b1;
        repeat (10) tick();

        // Gapped valid pattern 1,0,1,1 keeps its shape through both latencies
        begin_frame(16'd3);
        feed(13'd200, 1'b1);
        feed(13'd0, 1'b0);
        feed(13'd201, 1'b1);
        feed(13'd202, 1'b1);
        finish_frame();
        repeat (3) tick();

        chk("u1 queue drained", 64'(q1.size()), 64'd0);
        chk("u3 queue drained", 64'(q3.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rgb_bram_fetch.md
RGB_BRAM_FETCH -- requirements
Module: rgb_bram_fetch

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  ADDR_WIDTH, 13, pixel BRAM address width (8192 locations).
  MAX, 7056, first out-of-image address (84x84).
  RD_LATENCY, 1, BRAM read latency in cycles, legal range 1..4.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  synchronous active-low reset.
  start  in  1  frame start, sampled in IDLE only.
  frame_len  in  16  addresses per frame, captured on accepted start.
  addr_in  in  ADDR_WIDTH  pixel address from the address controller.
  addr_valid  in  1  addr_in is valid this cycle.
  bram_en  out  1  read enable to R/G/B BRAMs.
  bram_addr  out  ADDR_WIDTH  shared R/G/B BRAM address.
  dout_r  in  16  R BRAM read data.
  dout_g  in  16  G BRAM read data.
  dout_b  in  16  B BRAM read data.
  pixel_data  out  64  packed pixel {16'd0, R, G, B}.
  pixel_valid  out  1  pixel_data is valid, one-cycle pulse per address.
  busy  out  1  high in FETCH or DRAIN.
  frame_done  out  1  one-cycle pulse at frame end.
  addr_ovf  out  1  sticky flag: address arrived outside FETCH.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, FETCH, DRAIN, DONE.
REQ-004 IDLE->FETCH SHALL occur on start=1 when frame_len!=0; the address counter SHALL clear and frame_len SHALL be latched.
REQ-005 IDLE->DONE SHALL occur on start=1 when frame_len==0; no pixel_valid SHALL be produced for that frame.
REQ-006 In FETCH, each cycle with addr_valid=1 SHALL accept one address and increment the 16-bit accept counter.
REQ-007 FETCH->DRAIN SHALL occur on the cycle the counter reaches the latched frame_len.
REQ-008 DRAIN->DONE SHALL occur when no accepted address remains in the read pipeline.
REQ-009 DONE SHALL pulse frame_done for one cycle, then return to IDLE.
REQ-010 start SHALL be ignored in every state except IDLE; a latched frame_len SHALL NOT change mid-frame.
REQ-011 For an accepted address A with A<MAX: after edge k, bram_addr=A and bram_en=1.
REQ-012 For an accepted address A with A>=MAX (padding): bram_en=0, and bram_addr SHALL hold its previous value.
REQ-013 bram_en SHALL be 0 in every cycle with no accepted address.
REQ-014 An in-range flag and a valid bit SHALL travel a RD_LATENCY+1 stage shift register aligned with the BRAM data.
REQ-015 pixel_valid SHALL assert exactly RD_LATENCY+1 cycles after edge k, for one cycle per accepted address, with no gaps or reordering.
REQ-016 pixel_data SHALL be registered as {16'd0, dout_r, dout_g, dout_b} when the in-range flag is set, else 64'd0.
REQ-017 Back-to-back addr_valid SHALL yield back-to-back pixel_valid, at a throughput of one pixel per cycle.
REQ-018 addr_valid in IDLE, DRAIN or DONE SHALL be discarded and SHALL set addr_ovf; addr_ovf SHALL clear only on an accepted start or on reset.
REQ-019 busy SHALL be high in FETCH and DRAIN, low otherwise.
REQ-020 When pixel_valid=0, pixel_data SHALL hold its last value.

Reset
REQ-021 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the counter and pipeline.
REQ-022 That same reset SHALL force bram_en=0, bram_addr=0, pixel_data=0, pixel_valid=0, busy=0, frame_done=0 and addr_ovf=0.
REQ-023 Reset mid-frame SHALL discard in-flight reads; no pixel_valid SHALL follow the reset edge until a new accepted start.

Verification
REQ-024 frame_len=4; start; addresses 0,1,2,3 back-to-back; RD_LATENCY=1 -> pixel_valid high 2 cycles after each accept, 4 consecutive pulses, data {0,R[a],G[a],B[a]}, frame_done 1 cycle after DRAIN ends.
REQ-025 frame_len=3; addresses 7055, 7056, 7878 -> first pixel = BRAM data; second and third = 64'd0 with bram_en=0 on their issue cycles.
REQ-026 frame_len=0; start -> frame_done after 2 cycles, pixel_valid never asserted, busy stays 0.
REQ-027 addr_valid pulsed in IDLE, then in DRAIN -> addr_ovf=1 and stays set; the next accepted start clears it; no extra pixel_valid.
REQ-028 rst_n=0 for 1 cycle mid-FETCH with 2 reads in flight -> all outputs at reset values next cycle; zero pixel_valid afterwards until a new start.
REQ-029 RD_LATENCY=3 with gapped addr_valid (1,0,1,1) -> pixel_valid pattern (1,0,1,1) delayed by exactly 4 cycles.
